// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, with data
// priority, a starvation guard for fetch and in-order routing of read responses.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DW/8-1:0]   d_be,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]         starve_cnt;
    logic               fetch_pri;
    logic               push;
    logic [LATENCY-1:0] trk_vld;
    logic [LATENCY-1:0] trk_src;

    // A starved fetch overrides the normal data-first priority.
    assign fetch_pri = if_req && starve_cnt == SMAX;
    assign if_gnt    = rst_n && if_req && (fetch_pri || !d_req);
    assign d_gnt     = rst_n && d_req && !fetch_pri;

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_be    = if_gnt ? '1 : d_gnt ? d_be : '0;
        mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        push      = if_gnt | (d_gnt & ~d_we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            trk_vld    <= '0;
            trk_src    <= '0;
        end else begin
            starve_cnt <= (!if_req || if_gnt) ? 4'd0 :
                          (starve_cnt < SMAX) ? starve_cnt + 4'd1 : starve_cnt;
            trk_vld[0] <= push;
            trk_src[0] <= d_gnt;
            for (int i = 1; i < LATENCY; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_src[i] <= trk_src[i-1];
            end
        end
    end

    assign if_rvalid = trk_vld[LATENCY-1] & ~trk_src[LATENCY-1];
    assign d_rvalid  = trk_vld[LATENCY-1] & trk_src[LATENCY-1];
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, command muxing, starvation and
// response routing on a LATENCY=1 instance and a LATENCY=3 instance sharing stimulus.
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_be = 0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic [3:0]  mem_be3;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LATENCY(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_be(d_be),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    mem_port_arbiter #(.LATENCY(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3), .d_req(d_req), .d_we(d_we), .d_be(d_be),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
        .d_rdata(d_rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if_req = 1; d_req = 1;
        tick();
        #2;
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_d_gnt", 32'(d_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 0);
        tick();
        rst_n = 1; if_req = 0; d_req = 0;
        #2;
        chk("idle_gnts", {30'd0, if_gnt, d_gnt}, 0);
        chk("idle_mem_en", 32'(mem_en), 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_be", 32'(mem_be), 0);
        tick();
        #2;
        chk("idle_rvalids", {30'd0, if_rvalid, d_rvalid}, 0);

        // single fetch
        tick();
        if_req = 1; if_addr = 32'h100;
        #2;
        chk("f_if_gnt", 32'(if_gnt), 1);
        chk("f_d_gnt", 32'(d_gnt), 0);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", 32'(mem_we), 0);
        chk("f_mem_be", 32'(mem_be), 32'hf);
        tick();
        if_req = 0; mem_rdata = 32'hCAFE0001;
        #2;
        chk("f_if_rvalid", 32'(if_rvalid), 1);
        chk("f_if_rdata", if_rdata, 32'hCAFE0001);
        chk("f_d_rvalid", 32'(d_rvalid), 0);
        chk("f3_c1_rvalid", 32'(if_rvalid3), 0);
        tick();
        #2;
        chk("f_if_rvalid_gone", 32'(if_rvalid), 0);
        chk("f3_c2_rvalid", 32'(if_rvalid3), 0);
        tick();
        #2;
        chk("f3_c3_rvalid", 32'(if_rvalid3), 1);
        chk("f3_c3_d_rvalid", 32'(d_rvalid3), 0);
        tick();
        tick();

        // contention
        if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
        #2;
        chk("c_d_gnt", 32'(d_gnt), 1);
        chk("c_if_gnt", 32'(if_gnt), 0);
        chk("c_mem_addr", mem_addr, 32'h2000);
        tick();
        d_req = 0;
        #2;
        chk("c_if_gnt2", 32'(if_gnt), 1);
        chk("c_mem_addr2", mem_addr, 32'h104);
        chk("c_d_rvalid", 32'(d_rvalid), 1);
        chk("c_if_rvalid_early", 32'(if_rvalid), 0);
        tick();
        if_req = 0;
        #2;
        chk("c_if_rvalid", 32'(if_rvalid), 1);
        chk("c_d_rvalid_gone", 32'(d_rvalid), 0);
        repeat (4) tick();

        // starvation: data held high, fetch wins in cycle 4 only
        d_req = 1; d_we = 0; d_addr = 32'h3000; if_req = 1; if_addr = 32'h200;
        for (int c = 0; c < 6; c++) begin
            #2;
            chk($sformatf("s_d_gnt_c%0d", c), 32'(d_gnt), (c == 4) ? 0 : 1);
            chk($sformatf("s_if_gnt_c%0d", c), 32'(if_gnt), (c == 4) ? 1 : 0);
            if (c == 4) chk("s_mem_addr_c4", mem_addr, 32'h200);
            tick();
        end
        if_req = 0; d_req = 0;
        repeat (4) tick();

        // write
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        #2;
        chk("w_d_gnt", 32'(d_gnt), 1);
        chk("w_mem_we", 32'(mem_we), 1);
        chk("w_mem_be", 32'(mem_be), 32'h3);
        chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("w_mem_addr", mem_addr, 32'h40);
        tick();
        d_req = 0; d_we = 0;
        for (int c = 1; c < 5; c++) begin
            #2;
            chk($sformatf("w_no_rvalid_c%0d", c), {30'd0, d_rvalid, d_rvalid3}, 0);
            tick();
        end

        // reset mid-flight on the LATENCY=3 instance
        if_req = 1; if_addr = 32'h300;
        #2;
        chk("r_if_gnt3", 32'(if_gnt3), 1);
        tick();
        if_req = 0; rst_n = 0;
        #2;
        chk("r_rvalid3_c1", 32'(if_rvalid3), 0);
        chk("r_gnt_in_rst", 32'(mem_en3), 0);
        tick();
        rst_n = 1;
        for (int c = 2; c < 6; c++) begin
            #2;
            chk($sformatf("r_rvalid3_c%0d", c), 32'(if_rvalid3), 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
